layer_mac_engine: RTL and testbench

LAYER_MAC_ENGINE -- requirements
Module: layer_mac_engine

---
 rtl/layer_mac_engine.sv | 145 ++++++++++++++
 tb/tb_layer_mac_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_engine.sv
// Streaming multiply-accumulate layer: one activation beat per cycle feeds N_OUT
// parallel signed accumulators; a full pass is shifted, clamped and held for handshake.
module layer_mac_engine #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int N_IN     = 784,
  parameter int N_OUT    = 30,
  parameter int ACC_W    = DATA_W + WEIGHT_W + $clog2(N_IN) + 1,
  parameter int SHIFT    = 8,
  parameter int RELU     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_act,
  input  logic [N_OUT*WEIGHT_W-1:0]   in_weights,
  output logic [$clog2(N_IN)-1:0]     weight_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_OUT*DATA_W-1:0]     out_act,
  output logic                        busy
);

  localparam int IDX_W  = $clog2(N_IN);
  localparam int PROD_W = WEIGHT_W + DATA_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  localparam logic signed [ACC_W-1:0] U_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q [N_OUT];
  logic signed [ACC_W-1:0]  acc_d [N_OUT];
  logic signed [ACC_W-1:0]  acc_sum [N_OUT];
  logic [DATA_W-1:0]        lane_res [N_OUT];
  logic [N_OUT*DATA_W-1:0]  out_act_q, out_act_d;

  // Shift then clamp one accumulator into the output activation range.
  function automatic logic [DATA_W-1:0] sat_lane(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    s = acc >>> SHIFT;
    if (RELU != 0) begin
      if (s[ACC_W-1]) begin
        return '0;
      end else if (s > U_MAX) begin
        return '1;
      end else begin
        return s[DATA_W-1:0];
      end
    end else begin
      if (s > S_MAX) begin
        return {1'b0, {(DATA_W-1){1'b1}}};
      end else if (s < S_MIN) begin
        return {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        return s[DATA_W-1:0];
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_lane
      logic signed [WEIGHT_W-1:0] w;
      logic signed [DATA_W:0]     a;
      logic signed [PROD_W-1:0]   prod;

      assign w    = in_weights[gi*WEIGHT_W +: WEIGHT_W];
      // Activations are unsigned, so a zero MSB keeps them positive in the signed product.
      assign a    = {1'b0, in_act};
      assign prod = PROD_W'(w) * PROD_W'(a);
      assign acc_sum[gi]  = acc_q[gi] + ACC_W'(prod);
      assign lane_res[gi] = sat_lane(acc_sum[gi]);
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    out_act_d = out_act_q;
    in_ready  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_sum;
          if (cnt_q == LAST_IDX) begin
            // Result is taken from the post-add sum so out_valid follows the final beat by one cycle.
            state_d = ST_OUTPUT;
            for (int i = 0; i < N_OUT; i++) begin
              out_act_d[i*DATA_W +: DATA_W] = lane_res[i];
            end
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          for (int i = 0; i < N_OUT; i++) begin
            acc_d[i] = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      out_act_q <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_act_q <= out_act_d;
      acc_q     <= acc_d;
    end
  end

  assign out_valid  = (state_q == ST_OUTPUT);
  assign busy       = (state_q != ST_IDLE);
  assign weight_idx = cnt_q;
  assign out_act    = out_act_q;

endmodule

// File: tb/tb_layer_mac_engine.sv
// Three engine configurations share one stimulus stream; a negedge monitor
// pops hand-computed results from a queue on every output handshake.
module tb_layer_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_act = '0;
  logic [15:0] in_weights = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic        busy_w      [3];
  logic [1:0]  widx_w      [3];
  logic [15:0] out_act_w   [3];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer_mac_engine #(.N_IN(4), .N_OUT(2), .SHIFT(0), .RELU(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_act(in_act), .in_weights(in_weights), .weight_idx(widx_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_act(out_act_w[0]),
    .busy(busy_w[0]));

  layer_mac_engine #(.N_IN(4), .N_OUT(2), .SHIFT(0), .RELU(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_act(in_act), .in_weights(in_weights), .weight_idx(widx_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_act(out_act_w[1]),
    .busy(busy_w[1]));

  layer_mac_engine #(.N_IN(4), .N_OUT(2), .SHIFT(2), .RELU(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_act(in_act), .in_weights(in_weights), .weight_idx(widx_w[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_act(out_act_w[2]),
    .busy(busy_w[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every accepted result is compared for all three configurations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_w[0] && out_ready) begin
        chk("valid_align", {out_valid_w[1], out_valid_w[2]}, 2'b11);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {16'h0, out_act_w[0]}, 32'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          chk("out_relu_s0", out_act_w[0], e.a);
          chk("out_sign_s0", out_act_w[1], e.b);
          chk("out_relu_s2", out_act_w[2], e.c);
          $display("result relu_s0=%h sign_s0=%h relu_s2=%h", out_act_w[0], out_act_w[1], out_act_w[2]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Beat j drives act[j] with lane weights w0[j], w1[j].
  task automatic run_pass(input logic [3:0][7:0] act, input logic [3:0][7:0] w0,
                          input logic [3:0][7:0] w1, input int gap,
                          input bit push, input exp_t e);
    int n;
    if (push) exp_q.push_back(e);
    for (int j = 0; j < 4; j++) begin
      if (j > 0 && gap > 0) begin
        in_valid = 1'b0;
        in_act   = 8'hEE;
        repeat (gap) begin
          @(posedge clk); #1;
        end
        chk("stall_idx", widx_w[0], 32'(j));
      end
      in_act     = act[j];
      in_weights = {w1[j], w0[j]};
      in_valid   = 1'b1;
      chk("weight_idx", widx_w[0], 32'(j));
      n = 0;
      while (!in_ready_w[0] && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (n == 20) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      if (j == 0) chk("busy_after_beat", busy_w[0], 1'b1);
    end
    in_valid = 1'b0;
    chk("out_valid_latency", out_valid_w[0], 1'b1);
    chk("ready_low_output", in_ready_w[0], 1'b0);
    $display("pass issued act=%h w0=%h w1=%h gap=%0d", act, w0, w1, gap);
  endtask

  task automatic after_handshake();
    @(posedge clk); #1;
    chk("ready_after_out", in_ready_w[0], 1'b1);
    chk("busy_after_out", busy_w[0], 1'b0);
    chk("idx_after_out", widx_w[0], 32'd0);
  endtask

  localparam logic [3:0][7:0] ACT_1234 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [3:0][7:0] W_ONES   = {4{8'd1}};
  localparam logic [3:0][7:0] W_NEG1   = {4{8'hFF}};
  localparam logic [3:0][7:0] ACT_MAX  = {4{8'd255}};
  localparam logic [3:0][7:0] W_127    = {4{8'd127}};
  localparam logic [3:0][7:0] W_M128   = {4{8'h80}};
  localparam logic [3:0][7:0] W3_L0    = {8'd0, 8'd4, 8'd0, 8'd1};
  localparam logic [3:0][7:0] W3_L1    = {8'd0, 8'd0, 8'd0, 8'hFB};
  localparam logic [3:0][7:0] ACT_P4   = {8'd40, 8'd30, 8'd20, 8'd10};
  localparam logic [3:0][7:0] W4_L0    = {8'd2, 8'd1, 8'hFE, 8'd3};
  localparam logic [3:0][7:0] W4_L1    = {8'hFD, 8'd2, 8'hFF, 8'hFF};

  // acc {10,-10}, {129540,-130560}, {13,-5}, {100,-90}
  localparam exp_t E1 = '{a: 16'h000A, b: 16'hF60A, c: 16'h0002};
  localparam exp_t E2 = '{a: 16'h00FF, b: 16'h807F, c: 16'h00FF};
  localparam exp_t E3 = '{a: 16'h000D, b: 16'hFB0D, c: 16'h0003};
  localparam exp_t E4 = '{a: 16'h0064, b: 16'hA664, c: 16'h0019};

  initial begin
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_out_valid", out_valid_w[0], 1'b0);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_out_act", {out_act_w[0], out_act_w[1]}, 32'h0);
    chk("rst_idx", widx_w[0], 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready_w[0], 1'b1);

    run_pass(ACT_1234, W_ONES, W_NEG1, 0, 1'b1, E1);
    after_handshake();
    run_pass(ACT_MAX, W_127, W_M128, 0, 1'b1, E2);
    after_handshake();
    run_pass(ACT_1234, W3_L0, W3_L1, 0, 1'b1, E3);
    after_handshake();
    run_pass(ACT_P4, W4_L0, W4_L1, 0, 1'b1, E4);
    after_handshake();
    run_pass(ACT_1234, W_ONES, W_NEG1, 2, 1'b1, E1);
    after_handshake();

    // Backpressure with a new beat offered throughout the hold.
    out_ready = 1'b0;
    run_pass(ACT_P4, W4_L0, W4_L1, 0, 1'b1, E4);
    in_valid   = 1'b1;
    in_act     = 8'd99;
    in_weights = 16'h7F7F;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_ready_low", in_ready_w[0], 1'b0);
      chk("bp_out_stable", {out_act_w[0], out_act_w[1]}, {E4.a, E4.b});
      chk("bp_idx_hold", widx_w[0], 32'd3);
      $display("backpressure cycle %0d out_act=%h", k, out_act_w[0]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    after_handshake();
    run_pass(ACT_1234, W3_L0, W3_L1, 0, 1'b1, E3);
    after_handshake();

    // Abort after two beats, with a beat offered on the reset edge.
    in_act = 8'd255; in_weights = 16'h7F7F; in_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("partial_idx", widx_w[0], 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_idx", widx_w[0], 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("abort_no_valid", out_valid_w[0], 1'b0);
    run_pass(ACT_1234, W_ONES, W_NEG1, 0, 1'b1, E1);
    after_handshake();

    // Abort while the result is waiting; it must never be delivered.
    out_ready = 1'b0;
    run_pass(ACT_MAX, W_127, W_M128, 0, 1'b0, E2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("abort_out_valid", out_valid_w[0], 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    run_pass(ACT_P4, W4_L0, W4_L1, 0, 1'b1, E4);
    after_handshake();

    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
